// File: rtl/tiny_dnn_conv_seq.sv
// tiny_dnn_conv_seq: walks the conv loop nest and emits input/weight/output buffer addresses with accumulate framing.
// Define TINY_DNN_SEQ_BIAS_EN to add one bias beat ahead of each output pixel.
module tiny_dnn_conv_seq #(
    parameter int AW = 12
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          run,
    input  logic          enbias,
    input  logic [3:0]    od,
    input  logic [4:0]    oh,
    input  logic [4:0]    ow,
    input  logic [3:0]    id,
    input  logic [4:0]    kh,
    input  logic [4:0]    kw,
    input  logic [4:0]    iw,
    input  logic [9:0]    is,
    input  logic [9:0]    ks,
    input  logic [9:0]    fs,
    input  logic [9:0]    os,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] o_addr,
    output logic          first,
    output logic          acc_last,
    output logic          bias,
    output logic          busy,
    output logic          done
);
    // state | meaning
    // IDLE  | waiting for a rising edge of run
    // RUN   | presenting beats, counters advance on each handshake
    // DONE  | one-cycle completion pulse

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;
    logic   run_q;

    logic [3:0] sh_od, sh_id;
    logic [4:0] sh_oh, sh_ow, sh_kh, sh_kw, sh_iw;
    logic [9:0] sh_is, sh_ks, sh_fs, sh_os;

    logic [4:0] kx, ky, ox, oy, kx_n, ky_n, ox_n, oy_n;
    logic [3:0] ic, oc, ic_n, oc_n;
    logic       bph, nb, bias_start, bias_en, d_bias;

    logic          valid_n, busy_n, done_n, first_n, last_n, bias_n, ld_beat;
    logic [AW-1:0] in_n, w_n, o_n;

    logic       start, zero_dim, seq_end;
    logic [3:0] d_id;
    logic [4:0] d_ow, d_kh, d_kw, d_iw;
    logic [9:0] d_is, d_ks, d_fs, d_os;

    assign start    = (state == IDLE) && run && !run_q;
    assign zero_dim = (od == 4'd0) || (oh == 5'd0) || (ow == 5'd0) ||
                      (id == 4'd0) || (kh == 5'd0) || (kw == 5'd0);
    assign seq_end  = acc_last && (ox == sh_ow - 5'd1) && (oy == sh_oh - 5'd1) &&
                      (oc == sh_od - 4'd1);

    // The first beat is computed in the same cycle the shadows load, so read the live inputs in IDLE.
    assign d_id   = (state == IDLE) ? id : sh_id;
    assign d_ow   = (state == IDLE) ? ow : sh_ow;
    assign d_kh   = (state == IDLE) ? kh : sh_kh;
    assign d_kw   = (state == IDLE) ? kw : sh_kw;
    assign d_iw   = (state == IDLE) ? iw : sh_iw;
    assign d_is   = (state == IDLE) ? is : sh_is;
    assign d_ks   = (state == IDLE) ? ks : sh_ks;
    assign d_fs   = (state == IDLE) ? fs : sh_fs;
    assign d_os   = (state == IDLE) ? os : sh_os;
    assign d_bias = (state == IDLE) ? bias_start : bias_en;

`ifdef TINY_DNN_SEQ_BIAS_EN
    logic sh_bias;

    always_ff @(posedge S_AXI_ACLK) begin
        if (start) sh_bias <= enbias;
        if (!S_AXI_ARESETN) bph <= 1'b0;
        else                bph <= nb;
    end

    assign bias_start = enbias;
    assign bias_en    = sh_bias;
`else
    logic unused_enbias;
    assign unused_enbias = enbias;
    assign bph           = 1'b0;
    assign bias_start    = 1'b0;
    assign bias_en       = 1'b0;
`endif

    always_comb begin
        state_n = state;
        kx_n    = kx;
        ky_n    = ky;
        ic_n    = ic;
        ox_n    = ox;
        oy_n    = oy;
        oc_n    = oc;
        nb      = bph;
        valid_n = out_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        in_n    = in_addr;
        w_n     = w_addr;
        o_n     = o_addr;
        first_n = first;
        last_n  = acc_last;
        bias_n  = bias;
        ld_beat = 1'b0;

        case (state)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    if (zero_dim) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        kx_n    = 5'd0;
                        ky_n    = 5'd0;
                        ic_n    = 4'd0;
                        ox_n    = 5'd0;
                        oy_n    = 5'd0;
                        oc_n    = 4'd0;
                        nb      = bias_start;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        ld_beat = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!run) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                end else if (out_valid && out_ready) begin
                    if (bph) begin
                        nb = 1'b0;
                    end else begin
                        kx_n = kx + 5'd1;
                        if (kx == sh_kw - 5'd1) begin
                            kx_n = 5'd0;
                            ky_n = ky + 5'd1;
                            if (ky == sh_kh - 5'd1) begin
                                ky_n = 5'd0;
                                ic_n = ic + 4'd1;
                                if (ic == sh_id - 4'd1) begin
                                    ic_n = 4'd0;
                                    nb   = bias_en;
                                    ox_n = ox + 5'd1;
                                    if (ox == sh_ow - 5'd1) begin
                                        ox_n = 5'd0;
                                        oy_n = oy + 5'd1;
                                        if (oy == sh_oh - 5'd1) begin
                                            oy_n = 5'd0;
                                            oc_n = oc + 4'd1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    if (seq_end) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        ld_beat = 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (ld_beat) begin
            in_n    = nb ? '0 :
                      AW'(ic_n) * AW'(d_is) + (AW'(oy_n) + AW'(ky_n)) * AW'(d_iw) +
                      AW'(ox_n) + AW'(kx_n);
            w_n     = nb ? AW'(oc_n) :
                      AW'(oc_n) * AW'(d_fs) + AW'(ic_n) * AW'(d_ks) +
                      AW'(ky_n) * AW'(d_kw) + AW'(kx_n);
            o_n     = AW'(oc_n) * AW'(d_os) + AW'(oy_n) * AW'(d_ow) + AW'(ox_n);
            first_n = nb || (!d_bias && (ic_n == 4'd0) && (ky_n == 5'd0) && (kx_n == 5'd0));
            last_n  = !nb && (ic_n == d_id - 4'd1) && (ky_n == d_kh - 5'd1) &&
                      (kx_n == d_kw - 5'd1);
            bias_n  = nb;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state     <= IDLE;
            run_q     <= 1'b0;
            kx        <= 5'd0;
            ky        <= 5'd0;
            ic        <= 4'd0;
            ox        <= 5'd0;
            oy        <= 5'd0;
            oc        <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            o_addr    <= '0;
            first     <= 1'b0;
            acc_last  <= 1'b0;
            bias      <= 1'b0;
        end else begin
            state     <= state_n;
            run_q     <= run;
            kx        <= kx_n;
            ky        <= ky_n;
            ic        <= ic_n;
            ox        <= ox_n;
            oy        <= oy_n;
            oc        <= oc_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
            in_addr   <= in_n;
            w_addr    <= w_n;
            o_addr    <= o_n;
            first     <= first_n;
            acc_last  <= last_n;
            bias      <= bias_n;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (start) begin
            sh_od <= od;
            sh_oh <= oh;
            sh_ow <= ow;
            sh_id <= id;
            sh_kh <= kh;
            sh_kw <= kw;
            sh_iw <= iw;
            sh_is <= is;
            sh_ks <= ks;
            sh_fs <= fs;
            sh_os <= os;
        end
    end

endmodule

// File: tb/tb_tiny_dnn_conv_seq.sv
// Bench for tiny_dnn_conv_seq: nested-loop beat model, per-cycle compare process, randomized configs and ready.
module tb_tiny_dnn_conv_seq;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n, run, enbias, out_ready;
    logic [3:0] od, id;
    logic [4:0] oh, ow, kh, kw, iw;
    logic [9:0] is_v, ks, fs, os;
    logic out_valid, first, acc_last, bias, busy, done;
    logic [AW-1:0] in_addr, w_addr, o_addr;

    tiny_dnn_conv_seq #(.AW(AW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .run(run), .enbias(enbias),
        .od(od), .oh(oh), .ow(ow), .id(id), .kh(kh), .kw(kw), .iw(iw),
        .is(is_v), .ks(ks), .fs(fs), .os(os),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_addr(in_addr), .w_addr(w_addr), .o_addr(o_addr),
        .first(first), .acc_last(acc_last), .bias(bias), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] ia, wa, oa;
        logic f, l, b;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0, errors = 0;
    int beat_idx = 0;
    bit expect_done = 0, done_pend = 0, zero_ok = 0, abort_ok = 0, prev_stall = 0;
    int c_od, c_oh, c_ow, c_id, c_kh, c_kw, c_iw, c_is, c_ks, c_fs, c_os;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit bias_on(input bit en_b);
`ifdef TINY_DNN_SEQ_BIAS_EN
        return en_b;
`else
        return 1'b0;
`endif
    endfunction

    // Expected beat list straight from the loop nest definition.
    task automatic build_model(input bit with_bias);
        beat_t bt;
        exp_q.delete();
        for (int oc = 0; oc < c_od; oc++)
            for (int oy = 0; oy < c_oh; oy++)
                for (int ox = 0; ox < c_ow; ox++) begin
                    if (with_bias) begin
                        bt.ia = '0;
                        bt.wa = AW'(oc);
                        bt.oa = AW'(oc * c_os + oy * c_ow + ox);
                        bt.f = 1'b1; bt.l = 1'b0; bt.b = 1'b1;
                        exp_q.push_back(bt);
                    end
                    for (int ic = 0; ic < c_id; ic++)
                        for (int ky = 0; ky < c_kh; ky++)
                            for (int kx = 0; kx < c_kw; kx++) begin
                                bt.ia = AW'(ic * c_is + (oy + ky) * c_iw + ox + kx);
                                bt.wa = AW'(oc * c_fs + ic * c_ks + ky * c_kw + kx);
                                bt.oa = AW'(oc * c_os + oy * c_ow + ox);
                                bt.f = !with_bias && ic == 0 && ky == 0 && kx == 0;
                                bt.l = (ic == c_id - 1) && (ky == c_kh - 1) && (kx == c_kw - 1);
                                bt.b = 1'b0;
                                exp_q.push_back(bt);
                            end
                end
    endtask

    task automatic set_base();
        c_od = 1; c_oh = 2; c_ow = 2; c_id = 1; c_kh = 2; c_kw = 2;
        c_iw = 3; c_is = 9; c_ks = 4; c_fs = 4; c_os = 4;
    endtask

    task automatic set_rand();
        c_od = $urandom_range(1, 2); c_oh = $urandom_range(1, 3); c_ow = $urandom_range(1, 3);
        c_id = $urandom_range(1, 3); c_kh = $urandom_range(1, 3); c_kw = $urandom_range(1, 3);
        c_iw = $urandom_range(0, 31); c_is = $urandom_range(0, 1023); c_ks = $urandom_range(0, 1023);
        c_fs = $urandom_range(0, 1023); c_os = $urandom_range(0, 1023);
    endtask

    task automatic drive_dims();
        od = 4'(c_od); oh = 5'(c_oh); ow = 5'(c_ow); id = 4'(c_id); kh = 5'(c_kh); kw = 5'(c_kw);
        iw = 5'(c_iw); is_v = 10'(c_is); ks = 10'(c_ks); fs = 10'(c_fs); os = 10'(c_os);
    endtask

    task automatic scramble_dims();
        od = 4'($urandom); oh = 5'($urandom); ow = 5'($urandom); id = 4'($urandom);
        kh = 5'($urandom); kw = 5'($urandom); iw = 5'($urandom); is_v = 10'($urandom);
        ks = 10'($urandom); fs = 10'($urandom); os = 10'($urandom); enbias = 1'($urandom);
    endtask

    function automatic logic rdy(input int mode, input int n);
        if (mode == 1) return (n % 4 == 0) || (n % 4 == 3);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done_pend) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                done_pend = 0;
            end else if (!zero_ok) begin
                chk("no_spurious_done", done, 0);
            end
            if (out_valid) begin
                chk("busy_with_valid", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    chk($sformatf("in_addr[%0d]", beat_idx), in_addr, exp_q[0].ia);
                    chk($sformatf("w_addr[%0d]", beat_idx), w_addr, exp_q[0].wa);
                    chk($sformatf("o_addr[%0d]", beat_idx), o_addr, exp_q[0].oa);
                    chk($sformatf("first[%0d]", beat_idx), first, exp_q[0].f);
                    chk($sformatf("acc_last[%0d]", beat_idx), acc_last, exp_q[0].l);
                    chk($sformatf("bias[%0d]", beat_idx), bias, exp_q[0].b);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beat_idx++;
                        if (exp_q.size() == 0 && expect_done) done_pend = 1;
                    end
                end
            end else if (prev_stall && !abort_ok) begin
                chk("valid_held_in_stall", out_valid, 1);
            end
            prev_stall = out_valid && !out_ready;
        end
    end

    task automatic do_run(input int mode, input bit en_b);
        int n, nbeats;
        bit seen;
        drive_dims();
        enbias = en_b;
        build_model(bias_on(en_b));
        nbeats = exp_q.size();
        beat_idx = 0;
        expect_done = 1;
        @(posedge clk); #1;
        run = 1'b1;
        out_ready = rdy(mode, 0);
        n = 0; seen = 0;
        while (!seen && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) scramble_dims();
            if (done) seen = 1;
            else out_ready = rdy(mode, n);
        end
        chk("run_completes", seen, 1);
        chk("queue_drained", exp_q.size(), 0);
        if (mode == 0) chk("cycles_to_done", n, nbeats + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_restart_busy", busy, 0);
        run = 1'b0;
        out_ready = 1'b0;
        expect_done = 0;
        @(posedge clk); #1;
    endtask

    task automatic zero_run(input int which);
        set_rand();
        case (which)
            0: c_kw = 0;
            1: c_od = 0;
            2: c_oh = 0;
            default: c_id = 0;
        endcase
        drive_dims();
        exp_q.delete();
        zero_ok = 1;
        @(posedge clk); #1;
        run = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("zero_done_once", done, 0);
        chk("zero_busy_after", busy, 0);
        run = 1'b0;
        @(posedge clk); #1;
        zero_ok = 0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; run = 1'b0; enbias = 1'b0; out_ready = 1'b0;
        set_base();
        drive_dims();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_first", first, 0); chk("rst_last", acc_last, 0); chk("rst_bias", bias, 0);
        chk("rst_in", in_addr, 0); chk("rst_w", w_addr, 0); chk("rst_o", o_addr, 0);
        rst_n = 1'b1;

        // Pin the model to hand-derived values for the base configuration.
        set_base();
        build_model(1'b0);
        chk("model_len", exp_q.size(), 16);
        chk("model_b0", {exp_q[0].ia, exp_q[0].wa, exp_q[0].oa, 3'(exp_q[0].f)}, {12'd0, 12'd0, 12'd0, 3'd1});
        chk("model_b3", {exp_q[3].ia, exp_q[3].wa, 4'(exp_q[3].l)}, {12'd4, 12'd3, 4'd1});
        chk("model_b4", {exp_q[4].ia, exp_q[4].oa, 4'(exp_q[4].f)}, {12'd1, 12'd1, 4'd1});
        chk("model_b15", {exp_q[15].ia, exp_q[15].wa, exp_q[15].oa}, {12'd8, 12'd3, 12'd3});
`ifdef TINY_DNN_SEQ_BIAS_EN
        build_model(1'b1);
        chk("model_bias_len", exp_q.size(), 20);
        for (int i = 0; i < 20; i += 5) begin
            chk($sformatf("model_bias_b%0d", i), {exp_q[i].b, exp_q[i].wa}, {1'b1, 12'd0});
        end
`endif
        exp_q.delete();

        set_base(); do_run(0, 1'b0);
        set_base(); do_run(1, 1'b0);
        set_base(); do_run(0, 1'b1);
        set_base(); do_run(1, 1'b1);

        for (int z = 0; z < 4; z++) zero_run(z);

        // Abort after beat 5, then a clean restart from beat 0.
        set_base();
        drive_dims();
        enbias = 1'b0;
        build_model(1'b0);
        beat_idx = 0;
        @(posedge clk); #1;
        run = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (beat_idx < 6 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_beat5", beat_idx, 6);
        run = 1'b0;
        out_ready = 1'b0;
        abort_ok = 1;
        @(posedge clk); #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        abort_ok = 0;
        set_base(); do_run(0, 1'b0);

        // Synchronous reset in the middle of a run.
        set_rand();
        drive_dims();
        build_model(bias_on(1'b0));
        enbias = 1'b0;
        beat_idx = 0;
        @(posedge clk); #1;
        run = 1'b1;
        repeat (8) begin
            out_ready = rdy(2, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        run = 1'b0;
        abort_ok = 1;
        @(posedge clk); #1;
        chk("mrst_valid", out_valid, 0); chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
        chk("mrst_first", first, 0); chk("mrst_last", acc_last, 0); chk("mrst_bias", bias, 0);
        chk("mrst_in", in_addr, 0); chk("mrst_w", w_addr, 0); chk("mrst_o", o_addr, 0);
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_idle", out_valid, 0);
        abort_ok = 0;

        for (int r = 0; r < 10; r++) begin
            set_rand();
            do_run($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
